vec_load_unit: RTL and testbench
================================

Name: vec_load_unit

Overview:
- Vector load engine: fetches LANES consecutive 32-bit words from data memory, assembles one 256-bit vector, writes it into the vector register file through its write port (vwe3/vwa3/vwd3).
- Sits between the LSU/data-memory port and regfile_vec; it is the writer that drives that register file's write port.
- Vector registers are addressed 5'h10..5'h1F (bit 4 set; 5'h10 = vrf0, 5'h11 = vrf1).

Parameters:
- LANES, 8, number of 32-bit words per vector; vector width = LANES*32 = 256.
- TIMEOUT, 255, watchdog limit in cycles; used only with VLOAD_TIMEOUT_EN.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  one-cycle load command pulse.
- vd  in  5  destination vector register address.
- base_addr  in  32  byte address of lane 0.
- busy  out  1  high from the cycle after an accepted start until the write cycle, inclusive.
- done  out  1  one-cycle pulse, coincident with vwe3.
- err  out  1  one-cycle pulse on a rejected command or an abort.
- mem_req  out  1  memory read request.
- mem_addr  out  32  request byte address.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read data.
- vwe3  out  1  regfile write enable.
- vwa3  out  5  regfile write address.
- vwd3  out  256  regfile write data.

Behaviour:
- Reset (rst=0, async): state IDLE, lane index 0, data buffer 0. All outputs 0: busy, done, err, mem_req, mem_addr, vwe3, vwa3, vwd3. Reset mid-load discards the partial buffer; no regfile write occurs.
- FSM states: IDLE, REQ, WAIT, WRITE.
- IDLE:
  - start with vd[4]=1 and base_addr[1:0]=0: latch vd and base_addr, lane index := 0, go to REQ.
  - start with vd[4]=0 or base_addr[1:0]!=0: err=1 for one cycle, stay in IDLE. No request, no write.
- REQ: mem_req=1, mem_addr = base + 4*idx (mod 2^32, so wrap-around is allowed). Both are held stable until mem_gnt. On mem_gnt, go to WAIT.
- WAIT:
  - mem_req=0.
  - On mem_rvalid, store mem_rdata into lane idx, where lane i = buffer[32*i+31:32*i].
  - If idx==LANES-1, go to WRITE; else idx++ and go to REQ.
- WRITE: vwe3=1 and done=1 for exactly one cycle, vwa3=latched vd, vwd3=buffer. Then go to IDLE.
- vwa3/vwd3 continuously reflect the latched vd and buffer. Consumers sample them only when vwe3=1.
- Only one request is outstanding at a time. mem_rvalid outside WAIT is ignored.
- start while busy is ignored; the latched command is unchanged.
- Minimum latency with mem_gnt in the same cycle and mem_rvalid the next cycle: start accepted at cycle 0, vwe3 at cycle 2*LANES+1 (17 for LANES=8).
- busy is 0 in IDLE, including the cycle carrying err.

Optional Feature:
- Macro: VLOAD_TIMEOUT_EN.
- Defined: a counter resets on entry to REQ or WAIT and increments each cycle spent in REQ/WAIT for the current lane. On reaching TIMEOUT: err=1 for one cycle, mem_req=0, return to IDLE, no regfile write, buffer retained.
- Undefined: no counter; the unit waits indefinitely for mem_gnt/mem_rvalid, and err comes only from command rejection.

Test Plan:
- Normal load: start, vd=5'h10, base=32'h100. Memory grants immediately and returns word 8'hA0+i for lane i one cycle later. Expect: mem_addr sequence 0x100, 0x104, ..., 0x11C; one vwe3 pulse at cycle 17; vwa3=5'h10; vwd3 lane i = 32'h000000A0+i; done coincident with vwe3.
- Rejects: start with vd=5'h03 -> err pulse, no mem_req, busy=0. Start with base=32'h102 -> err pulse, no mem_req.
- Backpressure: mem_gnt delayed 3 cycles on lane 2 and rvalid delayed 4 cycles on lane 5 -> mem_req/mem_addr stable throughout, final vwd3 correct, vwe3 at cycle 24.
- Busy/stray inputs: second start with vd=5'h11 during a load -> ignored, write goes to 5'h10. mem_rvalid pulse while in IDLE -> no state change.
- Reset and wrap: rst=0 after lane 4 received -> all outputs 0 immediately, no vwe3 afterwards. Fresh load with base=32'hFFFFFFF0 -> addresses wrap to 0x00000000..0x0000000C for lanes 4..7.
- Timeout (VLOAD_TIMEOUT_EN, TIMEOUT=10): mem_rvalid withheld on lane 0 -> err pulse after 10 cycles in WAIT, return to IDLE, vwe3 never asserted.

Source files
------------

// File: rtl/vec_load_unit_if.sv
// Memory read port and vector register file write port of vec_load_unit.
// The master modport is the load unit; the slave side is memory plus regfile.
interface vec_load_unit_if #(
  parameter int LANES = 8
);
  logic                  mem_req;
  logic [31:0]           mem_addr;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [31:0]           mem_rdata;
  logic                  vwe3;
  logic [4:0]            vwa3;
  logic [LANES*32-1:0]   vwd3;

  modport master (
    output mem_req, mem_addr, vwe3, vwa3, vwd3,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_addr, vwe3, vwa3, vwd3,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/vec_load_unit.sv
// Vector load engine: fetches LANES words one request at a time and writes the vector to the VRF.
// Optional watchdog on stalled requests/responses is enabled with macro VLOAD_TIMEOUT_EN.
module vec_load_unit #(
  parameter int LANES   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic [4:0]      i_vd,
  input  logic [31:0]     i_base_addr,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_err,
  vec_load_unit_if.master bus
);

  localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, WRITE} state_t;

  state_t              r_state;
  logic [IW-1:0]       r_idx;
  logic [LANES*32-1:0] r_buf;
  logic [4:0]          r_vd;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic                r_vwe;
  logic                r_mem_req;
  logic [31:0]         r_mem_addr;

  wire w_cmd_ok = i_vd[4] && (i_base_addr[1:0] == 2'b00);
  wire w_last   = (r_idx == IW'(LANES - 1));

`ifdef VLOAD_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [TW-1:0] r_tcnt;
  // A stall is any cycle in REQ/WAIT where the current lane makes no progress
  wire w_stall  = ((r_state == REQ)  && !bus.mem_gnt) ||
                  ((r_state == WAIT) && !bus.mem_rvalid);
  wire w_expire = w_stall && (r_tcnt == TW'(TIMEOUT - 1));
`else
  wire w_unused_timeout = (TIMEOUT != 0);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_buf      <= '0;
      r_vd       <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_vwe      <= 1'b0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
`ifdef VLOAD_TIMEOUT_EN
      r_tcnt     <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_vwe  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            if (w_cmd_ok) begin
              r_vd       <= i_vd;
              r_idx      <= '0;
              r_mem_req  <= 1'b1;
              r_mem_addr <= i_base_addr;
              r_busy     <= 1'b1;
              r_state    <= REQ;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        REQ: begin
          if (bus.mem_gnt) begin
            r_mem_req <= 1'b0;
            r_state   <= WAIT;
          end
        end
        WAIT: begin
          if (bus.mem_rvalid) begin
            r_buf[32*int'(r_idx) +: 32] <= bus.mem_rdata;
            if (w_last) begin
              r_vwe   <= 1'b1;
              r_done  <= 1'b1;
              r_state <= WRITE;
            end else begin
              // Lane addresses advance by one word and wrap naturally at 2^32
              r_idx      <= r_idx + 1'b1;
              r_mem_req  <= 1'b1;
              r_mem_addr <= r_mem_addr + 32'd4;
              r_state    <= REQ;
            end
          end
        end
        WRITE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy    <= 1'b0;
          r_mem_req <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
`ifdef VLOAD_TIMEOUT_EN
      // Abort overrides the case above; the partially filled buffer is kept
      if (w_expire) begin
        r_tcnt    <= '0;
        r_err     <= 1'b1;
        r_mem_req <= 1'b0;
        r_busy    <= 1'b0;
        r_state   <= IDLE;
      end else if (w_stall) begin
        r_tcnt <= r_tcnt + 1'b1;
      end else begin
        r_tcnt <= '0;
      end
`endif
    end
  end

  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_err        = r_err;
  assign bus.mem_req  = r_mem_req;
  assign bus.mem_addr = r_mem_addr;
  assign bus.vwe3     = r_vwe;
  assign bus.vwa3     = r_vd;
  assign bus.vwd3     = r_buf;

endmodule

// File: tb/tb_vec_load_unit.sv
// Self-checking bench for vec_load_unit: directed loads, rejects, backpressure, reset, wrap,
// randomized loads against a lane-level reference model; timeout scenario under VLOAD_TIMEOUT_EN.
module tb_vec_load_unit;

`ifdef VLOAD_TIMEOUT_EN
  localparam int TO = 10;
`else
  localparam int TO = 255;
`endif

  logic        clk;
  logic        rst;
  logic        iStart;
  logic [4:0]  iVd;
  logic [31:0] iBase;
  logic        oBusy;
  logic        oDone;
  logic        oErr;

  int checks;
  int errors;

  logic [31:0]  words [8];
  int           gDly  [8];
  int           rDly  [8];
  logic [255:0] lastVec;

  vec_load_unit_if #(.LANES(8)) bus ();

  vec_load_unit #(.LANES(8), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (iStart),
    .i_vd        (iVd),
    .i_base_addr (iBase),
    .o_busy      (oBusy),
    .o_done      (oDone),
    .o_err       (oErr),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic idleInputs();
    iStart         = 1'b0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = $urandom;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Drives one load; memory answers per gDly/rDly. abortLane>=0 resets right after that lane returns.
  task automatic applyStimulus(input logic [4:0] vd, input logic [31:0] base,
                               input int abortLane, input bit injectStart);
    logic [255:0] expVec;
    logic [31:0]  expAddr;
    int           expCycle;
    int           cycle;
    int           lane;
    int           reqCnt;
    int           waitCnt;
    bit           inWait;
    bit           finished;
    bit           abortNow;

    expCycle = 1;
    for (int i = 0; i < 8; i++) begin
      expCycle += 2 + gDly[i] + rDly[i];
      expVec[32*i +: 32] = words[i];
    end

    iStart = 1'b1;
    iVd    = vd;
    iBase  = base;
    nextCycle();
    cycle    = 1;
    lane     = 0;
    reqCnt   = 0;
    waitCnt  = 0;
    inWait   = 1'b0;
    finished = 1'b0;
    abortNow = 1'b0;

    while (!finished && cycle < 200) begin
      idleInputs();
      if (injectStart && cycle == 3) begin
        iStart = 1'b1;
        iVd    = 5'h11;
        iBase  = 32'h0000_0200;
      end
      if (abortNow) begin
        #2;
        rst = 1'b0;
        #1;
        checkOutput("rstBusy", oBusy, 0);
        checkOutput("rstDone", oDone, 0);
        checkOutput("rstErr", oErr, 0);
        checkOutput("rstMemReq", bus.mem_req, 0);
        checkOutput("rstMemAddr", bus.mem_addr, 0);
        checkOutput("rstVwe3", bus.vwe3, 0);
        checkOutput("rstVwa3", bus.vwa3, 0);
        checkOutput("rstVwd3", bus.vwd3, 0);
        rst = 1'b1;
        lastVec = '0;
        for (int k = 0; k < 20; k++) begin
          nextCycle();
          checkOutput("noWriteAfterRst", bus.vwe3, 0);
        end
        return;
      end
      checkOutput("busyDuringLoad", oBusy, 1);
      if (bus.vwe3) begin
        checkOutput("vweCycle", cycle, expCycle);
        checkOutput("doneWithVwe", oDone, 1);
        checkOutput("vwa3", bus.vwa3, vd);
        checkOutput("vwd3", bus.vwd3, expVec);
        lastVec  = expVec;
        finished = 1'b1;
      end else if (!inWait && lane < 8) begin
        expAddr = base + 32'(4 * lane);
        checkOutput("memReq", bus.mem_req, 1);
        checkOutput("memAddr", bus.mem_addr, expAddr);
        if (reqCnt == gDly[lane]) begin
          bus.mem_gnt = 1'b1;
          inWait      = 1'b1;
          waitCnt     = 0;
        end
        reqCnt++;
      end else if (inWait) begin
        checkOutput("memReqLowInWait", bus.mem_req, 0);
        if (waitCnt == rDly[lane]) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = words[lane];
          inWait         = 1'b0;
          reqCnt         = 0;
          if (lane == abortLane) abortNow = 1'b1;
          lane++;
        end
        waitCnt++;
      end
      nextCycle();
      cycle++;
    end

    if (!finished) begin
      checkOutput("loadTimeout", cycle, expCycle);
    end else begin
      idleInputs();
      checkOutput("vweOnePulse", bus.vwe3, 0);
      checkOutput("doneOnePulse", oDone, 0);
      checkOutput("busyAfterWrite", oBusy, 0);
    end
  endtask

  task automatic applyReject(input logic [4:0] vd, input logic [31:0] base);
    iStart = 1'b1;
    iVd    = vd;
    iBase  = base;
    nextCycle();
    idleInputs();
    checkOutput("rejErr", oErr, 1);
    checkOutput("rejBusy", oBusy, 0);
    checkOutput("rejMemReq", bus.mem_req, 0);
    nextCycle();
    checkOutput("rejErrPulse", oErr, 0);
    checkOutput("rejMemReqAfter", bus.mem_req, 0);
    checkOutput("rejNoWrite", bus.vwe3, 0);
  endtask

  task automatic setDefaults();
    for (int i = 0; i < 8; i++) begin
      gDly[i]  = 0;
      rDly[i]  = 0;
      words[i] = 32'h0000_00A0 + 32'(i);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    lastVec = '0;
    rst     = 1'b0;
    iVd     = '0;
    iBase   = '0;
    idleInputs();
    #12;
    checkOutput("resetBusy", oBusy, 0);
    checkOutput("resetMemReq", bus.mem_req, 0);
    checkOutput("resetMemAddr", bus.mem_addr, 0);
    checkOutput("resetVwe3", bus.vwe3, 0);
    checkOutput("resetVwa3", bus.vwa3, 0);
    checkOutput("resetVwd3", bus.vwd3, 0);
    checkOutput("resetErr", oErr, 0);
    checkOutput("resetDone", oDone, 0);
    rst = 1'b1;
    nextCycle();

    setDefaults();
    applyStimulus(5'h10, 32'h0000_0100, -1, 1'b0);

    applyReject(5'h03, 32'h0000_0100);
    applyReject(5'h10, 32'h0000_0102);

    setDefaults();
    gDly[2] = 3;
    rDly[5] = 4;
    for (int i = 0; i < 8; i++) words[i] = $urandom;
    applyStimulus(5'h10, 32'h0000_0400, -1, 1'b0);

    setDefaults();
    for (int i = 0; i < 8; i++) words[i] = $urandom;
    applyStimulus(5'h10, 32'h0000_0800, -1, 1'b1);

    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hDEAD_BEEF;
    nextCycle();
    idleInputs();
    checkOutput("strayBusy", oBusy, 0);
    checkOutput("strayMemReq", bus.mem_req, 0);
    checkOutput("strayVwe", bus.vwe3, 0);
    checkOutput("strayVwd3", bus.vwd3, lastVec);
    nextCycle();
    checkOutput("strayVwdLater", bus.vwd3, lastVec);

    setDefaults();
    applyStimulus(5'h12, 32'h0000_1000, 4, 1'b0);

    setDefaults();
    for (int i = 0; i < 8; i++) words[i] = $urandom;
    applyStimulus(5'h1F, 32'hFFFF_FFF0, -1, 1'b0);

    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < 8; i++) begin
        words[i] = $urandom;
        gDly[i]  = $urandom_range(0, 3);
        rDly[i]  = $urandom_range(0, 3);
      end
      applyStimulus({1'b1, 4'($urandom)}, {30'($urandom), 2'b00}, -1, 1'b0);
    end

`ifdef VLOAD_TIMEOUT_EN
    begin
      int  cyc;
      bit  seenErr;
      bit  sawWrite;
      iStart  = 1'b1;
      iVd     = 5'h13;
      iBase   = 32'h0000_2000;
      nextCycle();
      cyc      = 1;
      seenErr  = 1'b0;
      sawWrite = 1'b0;
      while (!seenErr && cyc < 40) begin
        idleInputs();
        if (bus.vwe3) sawWrite = 1'b1;
        if (oErr) begin
          seenErr = 1'b1;
          checkOutput("toCycle", cyc, 12);
          checkOutput("toBusy", oBusy, 0);
          checkOutput("toMemReq", bus.mem_req, 0);
        end else if (bus.mem_req) begin
          bus.mem_gnt = 1'b1;
        end
        nextCycle();
        cyc++;
      end
      checkOutput("toErrSeen", seenErr, 1);
      checkOutput("toNoWrite", sawWrite, 0);
      idleInputs();
      checkOutput("toErrPulse", oErr, 0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
